frame_scan_ctrl: RTL and testbench
==================================

Name: frame_scan_ctrl

Overview:
Sequences one full-frame scan of the 80x60 frame buffer for the colour-processing datapath (filter plus column histogram). Waits for the capture side to flag a complete frame, then issues read addresses and read enables. Aligns row/column coordinates and sof/eol/eof strobes to the returned pixel, accounting for memory read latency. Honours back-pressure from the processing stage and generates the processed-image write address and write enable.

Parameters:
c_img_cols, 80, pixels per line
c_img_rows, 60, lines per frame
c_nb_img_pxls, 13, address width (80*60=4800 < 2^13)
c_nb_cols, 7, column counter width
c_nb_rows, 6, row counter width
c_rd_lat, 1, frame-buffer read latency in enabled cycles (1..3)

Ports:
clk  in  1  fpga clock
rst  in  1  reset, asynchronous, active-low
enable  in  1  allow new frame scans
frame_rdy  in  1  1-cycle pulse: capture finished a frame in buffer
proc_rdy  in  1  processing stage accepts current pixel
orig_addr  out  c_nb_img_pxls  frame-buffer read address
orig_en  out  1  read enable; memory output holds when low
pxl_vld  out  1  orig_pxl valid this cycle
pxl_col  out  c_nb_cols  column of valid pixel
pxl_row  out  c_nb_rows  row of valid pixel
sof  out  1  valid pixel is (0,0)
eol  out  1  valid pixel is last column
eof  out  1  valid pixel is last of frame
proc_addr  out  c_nb_img_pxls  processed-image write address
proc_we  out  1  processed-image write enable
busy  out  1  state is SCAN or FLUSH
frame_done  out  1  1-cycle pulse after last pixel accepted
frame_cnt  out  8  completed frames, wraps 255->0
overrun  out  1  sticky: frame_rdy lost

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; counters, pending flag and valid pipe cleared. Reset mid-scan aborts the frame, with no frame_done.
- FSM states:
  - IDLE: if enable=1 -> WAIT.
  - WAIT: if enable=0 -> IDLE; on frame_rdy or pending -> SCAN (pending cleared), with address counter at 0.
  - SCAN: issue addresses 0..c_img_cols*c_img_rows-1. After the last address is issued with advance=1 -> FLUSH.
  - FLUSH: drain the in-flight reads. When the eof pixel is accepted -> DONE.
  - DONE: one cycle; frame_done=1; frame_cnt+1. Then -> SCAN if pending and enable, else WAIT if enable, else IDLE.
- Pipeline stepping:
  - advance = proc_rdy & (SCAN | FLUSH).
  - orig_en = advance.
  - Address, row/col tags and the c_rd_lat-deep valid shift register step only when advance=1; all hold otherwise.
  - In FLUSH, a 0 enters the valid pipe.
- Outputs from the pipe tail:
  - pxl_vld, pxl_col, pxl_row, sof, eol, eof come from the tail stage.
  - A pixel is transferred when pxl_vld & proc_rdy. Outputs hold stable while proc_rdy=0.
  - proc_we = pxl_vld & proc_rdy (combinational). proc_addr = tail address.
- Counters: col wraps c_img_cols-1 -> 0, incrementing row. The address counter equals row*c_img_cols+col and needs no multiplier. Address max 4799.
- Latency: first pxl_vld appears c_rd_lat advancing cycles after entering SCAN. With proc_rdy held at 1, a frame takes 4800+c_rd_lat cycles in SCAN/FLUSH plus 1 in DONE.
- frame_rdy while SCAN/FLUSH/DONE:
  - pending clear -> set pending.
  - pending already set -> overrun=1, which stays set until reset.
  - frame_rdy in WAIT is consumed immediately. frame_rdy in IDLE is ignored.
- enable falling mid-frame: the current frame completes, then the FSM goes to IDLE. pending is kept.
- eol and eof are simultaneous on pixel 4799. sof on pixel 0 only.

Test Plan:
- Reset, enable=1, proc_rdy=1, single frame_rdy pulse, c_rd_lat=1:
  - Required response: orig_addr 0..4799 on consecutive cycles; pxl_vld from the next cycle; exactly 4800 proc_we pulses with proc_addr 0..4799.
  - Strobe checks: sof at addr 0; eol at cols 79; eof with row 59 col 79; frame_done once; frame_cnt=1.
- Back-pressure:
  - proc_rdy toggled in a 3-low/1-high pattern -> outputs stable during low cycles; no address skipped or duplicated; 4800 transfers total.
  - c_rd_lat=3 -> first pxl_vld 3 cycles after SCAN entry; last proc_addr 4799; FLUSH lasts 3 advancing cycles.
- Overlapping frames:
  - frame_rdy pulse mid-scan -> DONE goes directly to SCAN; frame_cnt=2 after both frames.
  - Two extra frame_rdy pulses mid-scan -> overrun=1, and it persists.
- Enable and reset mid-operation:
  - enable dropped at pixel 2000 -> frame finishes (4800 writes); FSM goes to IDLE; busy=0.
  - rst asserted at pixel 100 -> all outputs 0 immediately; no frame_done; next frame restarts at addr 0.
- frame_cnt wrap: 256 frames -> frame_cnt returns to 0.

Source files
------------

// File: rtl/frame_scan_ctrl.sv
// Frame-buffer scan sequencer: issues read addresses for one 80x60 frame and
// aligns pixel coordinates and sof/eol/eof strobes with the returned data.
module frame_scan_ctrl #(
  parameter int c_img_cols    = 80,
  parameter int c_img_rows    = 60,
  parameter int c_nb_img_pxls = 13,
  parameter int c_nb_cols     = 7,
  parameter int c_nb_rows     = 6,
  parameter int c_rd_lat      = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     frame_rdy,
  input  logic                     proc_rdy,
  output logic [c_nb_img_pxls-1:0] orig_addr,
  output logic                     orig_en,
  output logic                     pxl_vld,
  output logic [c_nb_cols-1:0]     pxl_col,
  output logic [c_nb_rows-1:0]     pxl_row,
  output logic                     sof,
  output logic                     eol,
  output logic                     eof,
  output logic [c_nb_img_pxls-1:0] proc_addr,
  output logic                     proc_we,
  output logic                     busy,
  output logic                     frame_done,
  output logic [7:0]               frame_cnt,
  output logic                     overrun
);

  localparam logic [c_nb_img_pxls-1:0] LAST_ADDR = c_nb_img_pxls'(c_img_cols * c_img_rows - 1);
  localparam logic [c_nb_cols-1:0]     LAST_COL  = c_nb_cols'(c_img_cols - 1);
  localparam logic [c_nb_rows-1:0]     LAST_ROW  = c_nb_rows'(c_img_rows - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_SCAN  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic                     vld;
    logic                     sof;
    logic                     eol;
    logic                     eof;
    logic [c_nb_img_pxls-1:0] addr;
    logic [c_nb_cols-1:0]     col;
    logic [c_nb_rows-1:0]     row;
  } stage_t;

  state_t                   state_q, state_d;
  logic [c_nb_img_pxls-1:0] addr_q, addr_d;
  logic [c_nb_cols-1:0]     col_q, col_d;
  logic [c_nb_rows-1:0]     row_q, row_d;
  stage_t [c_rd_lat-1:0]    pipe_q, pipe_d;
  logic                     pending_q, pending_d;
  logic                     overrun_q, overrun_d;
  logic [7:0]               frame_cnt_q, frame_cnt_d;

  stage_t stage_in_s;
  stage_t tail_s;
  logic   active_s;
  logic   advance_s;
  logic   xfer_s;

  assign active_s  = (state_q == ST_SCAN) || (state_q == ST_FLUSH);
  assign advance_s = proc_rdy & active_s;
  assign tail_s    = pipe_q[c_rd_lat-1];
  assign xfer_s    = tail_s.vld & proc_rdy;

  // State sequencing plus pending / overrun / frame count bookkeeping
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    overrun_d   = overrun_q;
    frame_cnt_d = frame_cnt_q;

    // A request arriving while a frame is in flight is remembered once; a second one is lost
    if (frame_rdy && (active_s || (state_q == ST_DONE))) begin
      if (pending_q) begin
        overrun_d = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end else begin
      overrun_d = overrun_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (frame_rdy || pending_q) begin
          state_d   = ST_SCAN;
          pending_d = 1'b0;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_SCAN: begin
        if (advance_s && (addr_q == LAST_ADDR)) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_SCAN;
        end
      end
      ST_FLUSH: begin
        if (xfer_s && tail_s.eof) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      ST_DONE: begin
        frame_cnt_d = frame_cnt_q + 8'd1;
        if (pending_q && enable) begin
          // The stored request is consumed; a request in this same cycle takes its place
          state_d   = ST_SCAN;
          pending_d = frame_rdy;
          overrun_d = overrun_q;
        end else if (enable) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Address/coordinate counters and the read-latency alignment pipe
  always_comb begin
    addr_d     = addr_q;
    col_d      = col_q;
    row_d      = row_q;
    pipe_d     = pipe_q;
    stage_in_s = '0;

    if (state_q == ST_SCAN) begin
      stage_in_s.vld  = 1'b1;
      stage_in_s.sof  = (addr_q == '0);
      stage_in_s.eol  = (col_q == LAST_COL);
      stage_in_s.eof  = (addr_q == LAST_ADDR);
      stage_in_s.addr = addr_q;
      stage_in_s.col  = col_q;
      stage_in_s.row  = row_q;
    end else begin
      stage_in_s = '0;
    end

    if ((state_q != ST_SCAN) && (state_d == ST_SCAN)) begin
      addr_d = '0;
      col_d  = '0;
      row_d  = '0;
    end else if (advance_s) begin
      for (int i = c_rd_lat - 1; i > 0; i--) begin
        pipe_d[i] = pipe_q[i-1];
      end
      pipe_d[0] = stage_in_s;
      if (state_q == ST_SCAN) begin
        // Row-major walk: the linear address tracks row*cols+col by plain increment
        addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + c_nb_img_pxls'(1'b1);
        if (col_q == LAST_COL) begin
          col_d = '0;
          row_d = (row_q == LAST_ROW) ? '0 : row_q + c_nb_rows'(1'b1);
        end else begin
          col_d = col_q + c_nb_cols'(1'b1);
          row_d = row_q;
        end
      end else begin
        addr_d = addr_q;
        col_d  = col_q;
        row_d  = row_q;
      end
    end else begin
      addr_d = addr_q;
      col_d  = col_q;
      row_d  = row_q;
      pipe_d = pipe_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      col_q       <= '0;
      row_q       <= '0;
      pipe_q      <= '0;
      pending_q   <= 1'b0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      col_q       <= col_d;
      row_q       <= row_d;
      pipe_q      <= pipe_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign orig_addr  = addr_q;
  assign orig_en    = advance_s;
  assign pxl_vld    = tail_s.vld;
  assign pxl_col    = tail_s.col;
  assign pxl_row    = tail_s.row;
  assign sof        = tail_s.sof;
  assign eol        = tail_s.eol;
  assign eof        = tail_s.eof;
  assign proc_addr  = tail_s.addr;
  assign proc_we    = xfer_s;
  assign busy       = active_s;
  assign frame_done = (state_q == ST_DONE);
  assign frame_cnt  = frame_cnt_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_frame_scan_ctrl.sv
// Scoreboard bench for frame_scan_ctrl: two full-size instances (read latency 1 and 3)
// share stimulus; a small-frame instance exercises the frame counter wrap.
module tb_frame_scan_ctrl;

  localparam int NPX = 4800;

  logic clk = 1'b0;
  logic rst, enable, frame_rdy, proc_rdy;
  logic en2, fr2, pr2;

  logic [12:0] oa0, pa0, oa1, pa1;
  logic [6:0]  pc0, pc1;
  logic [5:0]  pr0, pr1;
  logic [7:0]  fc0, fc1, fc2;
  logic oe0, pv0, sof0, eol0, eof0, pw0, bz0, fd0, ov0;
  logic oe1, pv1, sof1, eol1, eof1, pw1, bz1, fd1, ov1;
  logic [3:0]  oa2, pa2;
  logic [1:0]  pc2, prw2;
  logic oe2, pv2, sof2, eol2, eof2, pw2, bz2, fd2, ov2;

  frame_scan_ctrl #(.c_rd_lat(1)) u_dut0 (
    .clk(clk), .rst(rst), .enable(enable), .frame_rdy(frame_rdy), .proc_rdy(proc_rdy),
    .orig_addr(oa0), .orig_en(oe0), .pxl_vld(pv0), .pxl_col(pc0), .pxl_row(pr0),
    .sof(sof0), .eol(eol0), .eof(eof0), .proc_addr(pa0), .proc_we(pw0), .busy(bz0),
    .frame_done(fd0), .frame_cnt(fc0), .overrun(ov0));

  frame_scan_ctrl #(.c_rd_lat(3)) u_dut1 (
    .clk(clk), .rst(rst), .enable(enable), .frame_rdy(frame_rdy), .proc_rdy(proc_rdy),
    .orig_addr(oa1), .orig_en(oe1), .pxl_vld(pv1), .pxl_col(pc1), .pxl_row(pr1),
    .sof(sof1), .eol(eol1), .eof(eof1), .proc_addr(pa1), .proc_we(pw1), .busy(bz1),
    .frame_done(fd1), .frame_cnt(fc1), .overrun(ov1));

  frame_scan_ctrl #(.c_img_cols(4), .c_img_rows(3), .c_nb_img_pxls(4), .c_nb_cols(2),
                    .c_nb_rows(2), .c_rd_lat(2)) u_dut2 (
    .clk(clk), .rst(rst), .enable(en2), .frame_rdy(fr2), .proc_rdy(pr2),
    .orig_addr(oa2), .orig_en(oe2), .pxl_vld(pv2), .pxl_col(pc2), .pxl_row(prw2),
    .sof(sof2), .eol(eol2), .eof(eof2), .proc_addr(pa2), .proc_we(pw2), .busy(bz2),
    .frame_done(fd2), .frame_cnt(fc2), .overrun(ov2));

  always #5 clk = ~clk;

  logic [63:0] all0, all1;
  logic [29:0] obs0, obs1;
  assign all0 = {8'd0, oa0, oe0, pv0, pc0, pr0, sof0, eol0, eof0, pa0, pw0, bz0, fd0, fc0, ov0};
  assign all1 = {8'd0, oa1, oe1, pv1, pc1, pr1, sof1, eol1, eof1, pa1, pw1, bz1, fd1, fc1, ov1};
  assign obs0 = {pv0, sof0, eol0, eof0, pr0, pc0, pa0};
  assign obs1 = {pv1, sof1, eol1, eof1, pr1, pc1, pa1};

  int n_total = 0;
  int n_bad   = 0;

  logic [29:0] sb0[$];
  logic [29:0] sb1[$];

  int issue_cnt[2], flush_cnt[2], wr_cnt[2], adv_cnt[2], done_cnt[2];
  bit first_pend[2], busy_prev[2], hold_prev[2];
  logic [42:0] snap_prev[2];

  bit bp_on = 1'b0;
  int bp_ph = 0;
  int exp_done = 0;
  int done2 = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      proc_rdy = bp_on ? (bp_ph == 3) : 1'b1;
      bp_ph    = (bp_ph + 1) % 4;
    end
  endtask

  task automatic push_frame();
    logic [29:0] e;
    for (int r = 0; r < 60; r++) begin
      for (int c = 0; c < 80; c++) begin
        e = {1'b1, (r == 0 && c == 0), (c == 79), (r == 59 && c == 79),
             6'(r), 7'(c), 13'(r * 80 + c)};
        sb0.push_back(e);
        sb1.push_back(e);
      end
    end
  endtask

  task automatic pulse();
    frame_rdy = 1'b1;
    tick(1);
    frame_rdy = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (!(done_cnt[0] >= target && done_cnt[1] >= target) && n < budget) begin
      tick(1);
      n++;
    end
    check_val("done_wait", (done_cnt[0] >= target && done_cnt[1] >= target), 64'd1);
  endtask

  task automatic wait_wr(input int x, input int budget);
    int n;
    n = 0;
    tick(2);
    while (wr_cnt[0] < x && n < budget) begin
      tick(1);
      n++;
    end
    check_val("wr_wait", (wr_cnt[0] >= x), 64'd1);
  endtask

  // Per-instance monitor: issue order, first-pixel latency, scoreboard, hold stability, flush length
  task automatic mon(input int d, input logic [29:0] obs, input logic [12:0] oaddr,
                     input logic oen, input logic we, input logic bsy, input logic fd);
    int lat;
    logic [29:0] e;
    logic [42:0] snap;
    lat  = (d == 0) ? 1 : 3;
    snap = {obs, oaddr};
    if (bsy && !busy_prev[d]) begin
      issue_cnt[d] = 0; flush_cnt[d] = 0; wr_cnt[d] = 0; adv_cnt[d] = 0; first_pend[d] = 1'b1;
    end
    if (first_pend[d] && obs[29]) begin
      check_val("first_lat", adv_cnt[d], lat);
      first_pend[d] = 1'b0;
    end
    if (oen) begin
      adv_cnt[d]++;
      if (issue_cnt[d] < NPX) begin
        check_val("orig_addr", oaddr, issue_cnt[d]);
        issue_cnt[d]++;
      end else begin
        flush_cnt[d]++;
      end
    end
    if (we) begin
      wr_cnt[d]++;
      if (d == 0) begin
        check_val("sb_avail0", (sb0.size() > 0), 64'd1);
        if (sb0.size() > 0) begin e = sb0.pop_front(); check_val("pix0", obs, e); end
      end else begin
        check_val("sb_avail1", (sb1.size() > 0), 64'd1);
        if (sb1.size() > 0) begin e = sb1.pop_front(); check_val("pix1", obs, e); end
      end
    end
    if (hold_prev[d]) check_val("hold", snap, snap_prev[d]);
    hold_prev[d] = obs[29] & !we;
    snap_prev[d] = snap;
    if (fd) begin
      done_cnt[d]++;
      check_val("frame_wr", wr_cnt[d], NPX);
      check_val("flush_len", flush_cnt[d], lat);
    end
    busy_prev[d] = bsy;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      mon(0, obs0, oa0, oe0, pw0, bz0, fd0);
      mon(1, obs1, oa1, oe1, pw1, bz1, fd1);
    end else begin
      for (int d = 0; d < 2; d++) begin
        issue_cnt[d] = 0; flush_cnt[d] = 0; wr_cnt[d] = 0; adv_cnt[d] = 0;
        first_pend[d] = 1'b0; busy_prev[d] = 1'b0; hold_prev[d] = 1'b0;
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int d = 0; d < 2; d++) done_cnt[d] = 0;
    rst = 1'b1; enable = 1'b0; frame_rdy = 1'b0; proc_rdy = 1'b0;
    en2 = 1'b0; fr2 = 1'b0; pr2 = 1'b0;
    #2 rst = 1'b0;
    #2;
    check_val("rst_out0", all0, 64'd0);
    check_val("rst_out1", all1, 64'd0);
    tick(2);
    rst = 1'b1;
    enable = 1'b1;
    tick(2);

    // Single frame, no back-pressure
    push_frame(); pulse(); exp_done++;
    wait_done(exp_done, 6000);
    tick(1);
    check_val("fcnt_1a", fc0, 64'd1);
    check_val("fcnt_1b", fc1, 64'd1);
    check_val("ovr_0", ov0, 64'd0);

    // Back-pressure 3 low / 1 high
    bp_on = 1'b1;
    push_frame(); pulse(); exp_done++;
    wait_done(exp_done, 21000);
    bp_on = 1'b0;
    tick(1);
    check_val("fcnt_bp", fc1, 64'd2);

    // Overlapping request: DONE goes straight back to SCAN
    push_frame(); pulse();
    wait_wr(1000, 6000);
    push_frame(); pulse();
    wait_done(exp_done + 1, 6000);
    check_val("ovl_busy0", bz0, 64'd1);
    check_val("ovl_busy1", bz1, 64'd1);
    exp_done += 2;
    wait_done(exp_done, 6000);
    tick(1);
    check_val("fcnt_ovl", fc0, 64'd4);
    check_val("ovr_none", {ov0, ov1}, 64'd0);

    // Two extra requests mid-scan: second one is lost
    push_frame(); pulse();
    wait_wr(500, 6000);
    push_frame(); pulse();
    tick(10);
    pulse();
    tick(1);
    check_val("ovr_set", {ov0, ov1}, 64'd3);
    exp_done += 2;
    wait_done(exp_done, 12000);
    tick(1);
    check_val("fcnt_ovr", fc1, 64'd6);

    // Enable dropped mid-frame: frame completes, then IDLE ignores requests
    push_frame(); pulse(); exp_done++;
    wait_wr(2000, 6000);
    enable = 1'b0;
    wait_done(exp_done, 6000);
    tick(3);
    check_val("en_busy", {bz0, bz1}, 64'd0);
    check_val("fcnt_en", fc0, 64'd7);
    pulse();
    tick(30);
    check_val("idle_ign", done_cnt[0], exp_done);
    check_val("idle_busy", {bz0, bz1, oe0, oe1}, 64'd0);
    check_val("ovr_keep", {ov0, ov1}, 64'd3);

    // Reset mid-frame
    enable = 1'b1;
    tick(2);
    push_frame(); pulse();
    wait_wr(100, 6000);
    rst = 1'b0;
    #1;
    check_val("mid_rst0", all0, 64'd0);
    check_val("mid_rst1", all1, 64'd0);
    sb0.delete();
    sb1.delete();
    tick(5);
    check_val("rst_nodone", done_cnt[0] + done_cnt[1], 2 * exp_done);
    rst = 1'b1;
    tick(2);
    push_frame(); pulse(); exp_done++;
    wait_done(exp_done, 6000);
    tick(1);
    check_val("fcnt_rst", {fc0, fc1}, 64'h0101);
    check_val("ovr_rst", {ov0, ov1}, 64'd0);
    check_val("sb_left0", sb0.size(), 64'd0);
    check_val("sb_left1", sb1.size(), 64'd0);

    // Frame counter wrap on the small-frame instance
    en2 = 1'b1; pr2 = 1'b1;
    tick(2);
    for (int i = 0; i < 256; i++) begin
      fr2 = 1'b1;
      tick(1);
      fr2 = 1'b0;
      for (int j = 0; j < 60; j++) begin
        if (fd2) break;
        tick(1);
      end
      if (fd2) done2++;
      tick(1);
      if (i == 254) check_val("fcnt_255", fc2, 64'd255);
    end
    check_val("done2_cnt", done2, 64'd256);
    check_val("fcnt_wrap", fc2, 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
